divnorm_pipe: RTL and testbench

- Two-stage pipelined left-normalization shifter for divide/sqrt results.
- Sits directly downstream of the divsqrt shift-amount calculation. It consumes the quotient, the unbiased exponent DivUe, the shift amount, and the subnormal flag.
- Produces a normalized mantissa, a corrected exponent and sticky for the rounder.
- Uses valid/ready flow control so the rounder can stall without losing results.

---
 rtl/divnorm_pipe_pkg.sv | 17 +
 rtl/divnorm_pipe_divnormshift.sv | 13 +
 rtl/divnorm_pipe.sv | 125 ++++++++++++
 tb/tb_divnorm_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/divnorm_pipe_pkg.sv
// Shared constants and stage record for the divide/sqrt normalization shifter.
package divnorm_pipe_pkg;

    localparam int DIVNORM_WIDTH    = 64;
    localparam int DIVNORM_LOGW     = 6;
    localparam int DIVNORM_NE       = 11;
    localparam int DIVNORM_FINEBITS = 3;

    // One record type serves both the stage-1 and stage-2 pipeline registers.
    typedef struct packed {
        logic [DIVNORM_WIDTH-1:0] Mant;
        logic [DIVNORM_NE+1:0]    Ue;
        logic                     Sticky;
        logic                     Subnorm;
    } divnorm_stage_t;

endpackage

// File: rtl/divnorm_pipe_divnormshift.sv
// Parameterized combinational left barrel shifter; bits past the MSB are discarded.
module divnormshift #(
    parameter int W  = 64,
    parameter int SW = 6
) (
    input  logic [W-1:0]  in_i,
    input  logic [SW-1:0] amt_i,
    output logic [W-1:0]  out_o
);

    assign out_o = in_i << amt_i;

endmodule

// File: rtl/divnorm_pipe.sv
// Two-stage left-normalization shifter for divide/sqrt results with valid/ready flow.
// Defining DIVNORM_ONECYCLE_EN collapses stage 1 into combinational logic (1-cycle latency).
module divnorm_pipe
    import divnorm_pipe_pkg::*;
#(
    parameter int WIDTH    = DIVNORM_WIDTH,
    parameter int LOGW     = DIVNORM_LOGW,
    parameter int NE       = DIVNORM_NE,
    parameter int FINEBITS = DIVNORM_FINEBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             FlushE,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] Quot,
    input  logic             QuotSticky,
    input  logic [NE+1:0]    DivUe,
    input  logic [LOGW-1:0]  DivShiftAmt,
    input  logic             DivResSubnorm,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] NormMant,
    output logic [NE+1:0]    NormUe,
    output logic             NormSticky,
    output logic             NormSubnorm
);

    localparam logic [NE+1:0] UE_ONE = {{(NE+1){1'b0}}, 1'b1};

    logic                s2_vld_q;
    divnorm_stage_t      s2_q, s2_d;
    logic                ld1, ld2;
    logic                s1_vld;
    divnorm_stage_t      s1, s1_d;
    logic [FINEBITS-1:0] s1_fine, s1_fine_d;
    logic [LOGW-1:0]     coarse_amt;
    logic [WIDTH-1:0]    coarse_mant, fine_mant;

    assign ld2 = ~s2_vld_q | OutReady;

    // Coarse shift by the multiple-of-2^FINEBITS part of the amount.
    assign coarse_amt = {DivShiftAmt[LOGW-1:FINEBITS], {FINEBITS{1'b0}}};

    divnormshift #(.W(WIDTH), .SW(LOGW)) u_coarse (
        .in_i (Quot),
        .amt_i(coarse_amt),
        .out_o(coarse_mant)
    );

    assign s1_d      = '{Mant: coarse_mant, Ue: DivUe, Sticky: QuotSticky, Subnorm: DivResSubnorm};
    assign s1_fine_d = DivShiftAmt[FINEBITS-1:0];

`ifdef DIVNORM_ONECYCLE_EN
    assign ld1     = ld2;
    assign s1_vld  = InValid;
    assign s1      = s1_d;
    assign s1_fine = s1_fine_d;
`else
    logic                s1_vld_q;
    divnorm_stage_t      s1_q;
    logic [FINEBITS-1:0] s1_fine_q;

    assign ld1 = ~s1_vld_q | ld2;

    // Stage 1 boundary: data only moves on an actual transfer, so bubbles keep old contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s1_q      <= '0;
            s1_fine_q <= '0;
        end else if (FlushE) begin
            s1_vld_q <= 1'b0;
        end else if (ld1) begin
            s1_vld_q <= InValid;
            if (InValid) begin
                s1_q      <= s1_d;
                s1_fine_q <= s1_fine_d;
            end
        end
    end

    assign s1_vld  = s1_vld_q;
    assign s1      = s1_q;
    assign s1_fine = s1_fine_q;
`endif

    assign InReady = ld1;

    divnormshift #(.W(WIDTH), .SW(FINEBITS)) u_fine (
        .in_i (s1.Mant),
        .amt_i(s1_fine),
        .out_o(fine_mant)
    );

    // A normal nonzero result whose MSB is still clear needs one more bit of shift.
    always_comb begin
        s2_d      = s1;
        s2_d.Mant = fine_mant;
        if (~s1.Subnorm & ~fine_mant[WIDTH-1] & (|fine_mant)) begin
            s2_d.Mant = fine_mant << 1;
            s2_d.Ue   = s1.Ue - UE_ONE;
        end
    end

    // Stage 2 boundary: output register, held while the rounder stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_vld_q <= 1'b0;
            s2_q     <= '0;
        end else if (FlushE) begin
            s2_vld_q <= 1'b0;
        end else if (ld2) begin
            s2_vld_q <= s1_vld;
            if (s1_vld) s2_q <= s2_d;
        end
    end

    assign OutValid    = s2_vld_q;
    assign NormMant    = s2_q.Mant;
    assign NormUe      = s2_q.Ue;
    assign NormSticky  = s2_q.Sticky;
    assign NormSubnorm = s2_q.Subnorm;

endmodule

// File: tb/tb_divnorm_pipe.sv
// Self-checking bench for divnorm_pipe: directed latency/stall/flush/reset steps plus random traffic.
module tb_divnorm_pipe;

`ifdef DIVNORM_ONECYCLE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [63:0] m;
        logic [12:0] ue;
        logic        st;
        logic        sb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, FlushE, InValid, InReady;
    logic [63:0] Quot;
    logic        QuotSticky;
    logic [12:0] DivUe;
    logic [5:0]  DivShiftAmt;
    logic        DivResSubnorm;
    logic        OutValid, OutReady;
    logic [63:0] NormMant;
    logic [12:0] NormUe;
    logic        NormSticky, NormSubnorm;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t expq[$];

    always #5 clk = ~clk;

    divnorm_pipe dut (
        .clk(clk), .reset(reset), .FlushE(FlushE),
        .InValid(InValid), .InReady(InReady),
        .Quot(Quot), .QuotSticky(QuotSticky), .DivUe(DivUe),
        .DivShiftAmt(DivShiftAmt), .DivResSubnorm(DivResSubnorm),
        .OutValid(OutValid), .OutReady(OutReady),
        .NormMant(NormMant), .NormUe(NormUe),
        .NormSticky(NormSticky), .NormSubnorm(NormSubnorm)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: full left shift in one step, then the MSB-clear correction for normal results.
    function automatic exp_t model(input logic [63:0] q, input logic [5:0] a,
                                   input logic [12:0] ue, input logic st, input logic sb);
        exp_t e;
        logic [63:0] full;
        full = q << a;
        e.m  = full;
        e.ue = ue;
        e.st = st;
        e.sb = sb;
        if (!sb && full != 64'd0 && !full[63]) begin
            e.m  = full << 1;
            e.ue = ue - 13'd1;
        end
        return e;
    endfunction

    // Scoreboard: outputs leave in order; a flush discards everything still in flight.
    always @(negedge clk) begin
        if (reset) begin
            expq.delete();
        end else begin
            if (OutValid && OutReady) begin
                if (expq.size() == 0) begin
                    chk("spurious_outvalid", 64'(OutValid), 64'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("sb_mant", NormMant, e.m);
                    chk("sb_ue", 64'(NormUe), 64'(e.ue));
                    chk("sb_sticky", 64'(NormSticky), 64'(e.st));
                    chk("sb_subnorm", 64'(NormSubnorm), 64'(e.sb));
                end
            end
            if (FlushE) expq.delete();
            else if (InValid && InReady)
                expq.push_back(model(Quot, DivShiftAmt, DivUe, QuotSticky, DivResSubnorm));
        end
    end

    task automatic drive(input logic v, input logic [63:0] q, input logic [5:0] a,
                         input logic [12:0] ue, input logic st, input logic sb);
        InValid = v; Quot = q; DivShiftAmt = a; DivUe = ue; QuotSticky = st; DivResSubnorm = sb;
    endtask

    task automatic single(input string tag, input logic [63:0] q, input logic [5:0] a,
                          input logic [12:0] ue, input logic sb,
                          input logic [63:0] em, input logic [12:0] eue);
        OutReady = 1'b1;
        @(posedge clk); #1; drive(1'b1, q, a, ue, 1'b0, sb);
        @(posedge clk); #1; InValid = 1'b0;
        repeat (LAT - 1) begin
            @(negedge clk);
            chk({tag, "_early_valid"}, 64'(OutValid), 64'd0);
        end
        @(negedge clk);
        chk({tag, "_valid"}, 64'(OutValid), 64'd1);
        chk({tag, "_mant"}, NormMant, em);
        chk({tag, "_ue"}, 64'(NormUe), 64'(eue));
        chk({tag, "_subnorm"}, 64'(NormSubnorm), 64'(sb));
        @(negedge clk);
        chk({tag, "_valid_drops"}, 64'(OutValid), 64'd0);
    endtask

    initial begin
        int          acc, first_block, have_held;
        logic [63:0] held;
        logic [5:0]  ra;
        logic [63:0] rq;

        reset = 1'b1; FlushE = 1'b0; OutReady = 1'b1;
        drive(1'b0, 64'd0, 6'd0, 13'd0, 1'b0, 1'b0);
        #3;
        chk("rst_outvalid", 64'(OutValid), 64'd0);
        chk("rst_mant", NormMant, 64'd0);
        chk("rst_ue", 64'(NormUe), 64'd0);
        chk("rst_sticky", 64'(NormSticky), 64'd0);
        chk("rst_subnorm", 64'(NormSubnorm), 64'd0);
        chk("rst_inready", 64'(InReady), 64'd1);
        @(posedge clk); #1; reset = 1'b0;

        single("t1_nocorr", 64'h1, 6'd63, 13'd5, 1'b0, 64'h8000_0000_0000_0000, 13'd5);
        single("t2_corr", 64'h1, 6'd62, 13'd5, 1'b0, 64'h8000_0000_0000_0000, 13'd4);
        single("t3_subnorm", 64'h1, 6'd10, 13'h1FFD, 1'b1, 64'h400, 13'h1FFD);
        single("t_zero", 64'h0, 6'd17, 13'd9, 1'b0, 64'h0, 13'd9);
        single("t_wrap", 64'h1, 6'd0, 13'd0, 1'b0, 64'h2, 13'h1FFF);

        // Back-to-back inputs into a stalled consumer.
        acc = 0; first_block = -1; have_held = 0; held = '0;
        for (int cyc = 0; cyc < 20 && acc < 4; cyc++) begin
            @(posedge clk); #1;
            drive(1'b1, 64'h3 << acc, 6'(8 * acc + 3), 13'(100 + acc), acc[0], 1'b0);
            OutReady = (cyc >= 5);
            @(negedge clk);
            if (!InReady && first_block < 0) begin
                first_block = acc;
                chk("stall_accepted_before_block", 64'(acc), 64'(LAT));
            end
            if (OutValid && !OutReady) begin
                if (have_held != 0) chk("stall_hold_mant", NormMant, held);
                else begin held = NormMant; have_held = 1; end
            end
            if (InReady) acc++;
        end
        @(posedge clk); #1; InValid = 1'b0; OutReady = 1'b1;
        chk("stall_all_accepted", 64'(acc), 64'd4);
        chk("stall_inready_dropped", 64'(first_block >= 0), 64'd1);
        repeat (6) @(posedge clk);
        #1;

        // Flush with both stages occupied.
        OutReady = 1'b0;
        drive(1'b1, 64'h5, 6'd20, 13'd33, 1'b1, 1'b0);
        @(posedge clk); #1; drive(1'b1, 64'h7, 6'd30, 13'd44, 1'b0, 1'b1);
        @(posedge clk); #1; InValid = 1'b0;
        @(negedge clk);
        chk("flush_pre_valid", 64'(OutValid), 64'd1);
        @(posedge clk); #1; FlushE = 1'b1;
        @(posedge clk); #1; FlushE = 1'b0;
        @(negedge clk);
        chk("flush_valid_cleared", 64'(OutValid), 64'd0);
        single("t_after_flush", 64'h1, 6'd63, 13'd7, 1'b0, 64'h8000_0000_0000_0000, 13'd7);

        // Asynchronous reset with results in flight.
        OutReady = 1'b0;
        @(posedge clk); #1; drive(1'b1, 64'h1, 6'd63, 13'd5, 1'b1, 1'b1);
        @(posedge clk); #1; drive(1'b1, 64'h3, 6'd40, 13'd6, 1'b1, 1'b0);
        @(posedge clk); #1; InValid = 1'b0;
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("arst_outvalid", 64'(OutValid), 64'd0);
        chk("arst_mant", NormMant, 64'd0);
        chk("arst_ue", 64'(NormUe), 64'd0);
        chk("arst_sticky", 64'(NormSticky), 64'd0);
        chk("arst_subnorm", 64'(NormSubnorm), 64'd0);
        chk("arst_inready", 64'(InReady), 64'd1);
        repeat (2) @(posedge clk);
        #1; reset = 1'b0; OutReady = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("arst_no_outvalid", 64'(OutValid), 64'd0);
        end

        // Random traffic with random back-pressure and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            ra = 6'($urandom_range(0, 63));
            rq = {$urandom, $urandom} >> ra;
            if ($urandom_range(0, 7) == 0) rq = 64'd0;
            drive($urandom_range(0, 3) != 0, rq, ra,
                  ($urandom_range(0, 7) == 0) ? 13'd0 : 13'($urandom),
                  1'($urandom), ($urandom_range(0, 5) == 0));
            OutReady = ($urandom_range(0, 3) != 0);
            FlushE   = ($urandom_range(0, 31) == 0);
        end
        @(posedge clk); #1;
        InValid = 1'b0; FlushE = 1'b0; OutReady = 1'b1;
        for (int w = 0; w < 10 && expq.size() != 0; w++) @(negedge clk);
        @(negedge clk);
        chk("drain_queue_empty", 64'(expq.size()), 64'd0);
        chk("drain_outvalid_low", 64'(OutValid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
